// File: rtl/demux_1to4_32b.sv
// Registered 1-to-4 word demux with per-channel valid/ready holding registers.
// Define DEMUX_AUTO_SEL_EN to route round-robin from an internal pointer instead of sel.
`ifndef INTERNAL_BITS
`define INTERNAL_BITS 32
`endif

module demux_1to4_32b (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                sel,
  input  logic [`INTERNAL_BITS-1:0] Data_in,
  output logic [3:0]                out_valid,
  input  logic [3:0]                out_ready,
  output logic [`INTERNAL_BITS-1:0] Data_out1,
  output logic [`INTERNAL_BITS-1:0] Data_out2,
  output logic [`INTERNAL_BITS-1:0] Data_out3,
  output logic [`INTERNAL_BITS-1:0] Data_out4
);

  localparam int W = `INTERNAL_BITS;

  logic [3:0]   full_q, full_d;
  logic [W-1:0] data_q [4];
  logic [1:0]   tgt;
  logic         load;

`ifdef DEMUX_AUTO_SEL_EN
  logic [1:0] ptr_q, ptr_d;
  logic       unused_sel;

  assign unused_sel = ^sel;
  assign tgt        = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (clr)
      ptr_d = 2'd0;
    else if (load)
      ptr_d = ptr_q + 2'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ptr_q <= 2'd0;
    else
      ptr_q <= ptr_d;
  end
`else
  assign tgt = sel;
`endif

  assign in_ready = !clr && (!full_q[tgt] || out_ready[tgt]);
  assign load     = in_valid && in_ready;

  // A load wins over a drain on the same channel, so no bubble appears.
  always_comb begin
    full_d = full_q;
    for (int k = 0; k < 4; k++) begin
      if (clr)
        full_d[k] = 1'b0;
      else if (load && (tgt == 2'(k)))
        full_d[k] = 1'b1;
      else if (full_q[k] && out_ready[k])
        full_d[k] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      full_q <= 4'b0000;
    else
      full_q <= full_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++)
        data_q[k] <= '0;
    end else if (load) begin
      data_q[tgt] <= Data_in;
    end
  end

  assign out_valid = full_q;
  assign Data_out1 = data_q[0];
  assign Data_out2 = data_q[1];
  assign Data_out3 = data_q[2];
  assign Data_out4 = data_q[3];

endmodule

// File: tb/tb_demux_1to4_32b.sv
// Bench for demux_1to4_32b: directed scenarios plus random traffic
// checked against a channel-occupancy model.
module tb_demux_1to4_32b;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  sel;
  logic [31:0] Data_in;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] Data_out1, Data_out2, Data_out3, Data_out4;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: which channels hold a word, what word, and round-robin slot
  bit          m_full [4];
  logic [31:0] m_data [4];
  int          m_ptr;

  always #5 clk = ~clk;

  demux_1to4_32b dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .Data_in   (Data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Data_out1 (Data_out1),
    .Data_out2 (Data_out2),
    .Data_out3 (Data_out3),
    .Data_out4 (Data_out4)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic int m_tgt();
`ifdef DEMUX_AUTO_SEL_EN
    return m_ptr;
`else
    return int'(sel);
`endif
  endfunction

  function automatic bit m_rdy();
    int t = m_tgt();
    if (clr) return 1'b0;
    return !m_full[t] || out_ready[t];
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 4; k++) begin
      m_full[k] = 1'b0;
      m_data[k] = 32'h0;
    end
    m_ptr = 0;
  endtask

  task automatic check_outs(input string tag);
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = m_full[k];
    chk({tag, ".vld"}, 32'(out_valid), 32'(v));
    chk({tag, ".d1"}, Data_out1, m_data[0]);
    chk({tag, ".d2"}, Data_out2, m_data[1]);
    chk({tag, ".d3"}, Data_out3, m_data[2]);
    chk({tag, ".d4"}, Data_out4, m_data[3]);
  endtask

  // One clock: drive, check in_ready mid-cycle, advance model, check outputs.
  task automatic cyc(input bit v, input logic [1:0] s, input logic [31:0] d,
                     input logic [3:0] r, input bit c, input string tag);
    bit rdy;
    bit acc;
    int t;
    in_valid  = v;
    sel       = s;
    Data_in   = d;
    out_ready = r;
    clr       = c;
    @(negedge clk);
    rdy = m_rdy();
    t   = m_tgt();
    acc = v && rdy;
    chk({tag, ".rdy"}, 32'(in_ready), 32'(rdy));
    if (c) begin
      for (int k = 0; k < 4; k++) m_full[k] = 1'b0;
      m_ptr = 0;
    end else begin
      for (int k = 0; k < 4; k++)
        if (m_full[k] && r[k]) m_full[k] = 1'b0;
      if (acc) begin
        m_full[t] = 1'b1;
        m_data[t] = d;
        m_ptr     = (m_ptr + 1) % 4;
      end
    end
    @(posedge clk);
    #1;
    check_outs(tag);
  endtask

  initial begin
    rst       = 1'b0;
    clr       = 1'(($urandom));
    in_valid  = 1'b1;
    sel       = 2'($urandom);
    Data_in   = $urandom;
    out_ready = 4'($urandom);
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset");
    rst = 1'b1;

    // routing with all consumers stalled
    cyc(1, 2'd0, 32'h11111111, 4'b0000, 0, "route0");
    cyc(1, 2'd1, 32'h22222222, 4'b0000, 0, "route1");
    cyc(1, 2'd2, 32'h33333333, 4'b0000, 0, "route2");
    cyc(1, 2'd3, 32'h44444444, 4'b0000, 0, "route3");
`ifndef DEMUX_AUTO_SEL_EN
    chk("route.all", 32'(out_valid), 32'h0000000f);
    chk("route.d3", Data_out3, 32'h33333333);
`endif
    cyc(1, 2'd2, 32'h55555555, 4'b0000, 0, "route5");
`ifndef DEMUX_AUTO_SEL_EN
    chk("route5.d3", Data_out3, 32'h33333333);
`endif

    // simultaneous drain and reload on a full channel
    cyc(1, 2'd1, 32'hAAAA0001, 4'b0010, 0, "pass1");
    cyc(1, 2'd1, 32'hAAAA0002, 4'b0010, 0, "pass2");
`ifndef DEMUX_AUTO_SEL_EN
    chk("pass.d2", Data_out2, 32'hAAAA0002);
    chk("pass.vld1", 32'(out_valid[1]), 32'd1);
`endif

    // empty channels 1 and 2, then drain 0/3 while loading 2
    cyc(0, 2'd0, 32'h0, 4'b0110, 0, "empty12");
    cyc(1, 2'd2, 32'hBEEF0002, 4'b1001, 0, "indep");
`ifndef DEMUX_AUTO_SEL_EN
    chk("indep.vld", 32'(out_valid), 32'h00000004);
`endif

    // refill everything, then clear with traffic present
    cyc(1, 2'd0, 32'hC0000000, 4'b0000, 0, "fill0");
    cyc(1, 2'd1, 32'hC0000001, 4'b0000, 0, "fill1");
    cyc(1, 2'd3, 32'hC0000003, 4'b0000, 0, "fill3");
    cyc(1, 2'd0, 32'hDEADDEAD, 4'b1111, 1, "clr");
`ifndef DEMUX_AUTO_SEL_EN
    chk("clr.vld", 32'(out_valid), 32'h0);
    chk("clr.d1", Data_out1, 32'hC0000000);
`endif

    // back-to-back words with every consumer taking
    for (int i = 0; i < 6; i++)
      cyc(1, 2'd3, 32'hF0000000 + i, 4'b1111, 0, "b2b");
`ifdef DEMUX_AUTO_SEL_EN
    chk("b2b.d1", Data_out1, 32'hF0000004);
    chk("b2b.d2", Data_out2, 32'hF0000005);
`endif

    // random traffic with occasional clear and mid-run reset
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b0;
        #2;
        m_reset();
        check_outs("arst");
        @(posedge clk);
        #1;
        rst = 1'b1;
      end
      cyc(1'($urandom_range(0, 3) != 0), 2'($urandom), $urandom,
          4'($urandom) & 4'($urandom),
          $urandom_range(0, 63) == 0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
